// File: rtl/heart_sequencer_pkg.sv
// Shared types for the heart sprite sequencer: beat FSM states and bounce direction.
package heart_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LUB  = 3'd1,
        S_GAP  = 3'd2,
        S_DUB  = 3'd3,
        S_REST = 3'd4
    } state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    function automatic logic is_beat(input state_t s);
        return (s == S_LUB) || (s == S_DUB);
    endfunction

endpackage

// File: rtl/heart_sequencer_bounce_axis.sv
// One screen axis of the bouncing heart: position/direction registers with edge reflection.
module bounce_axis
    import heart_sequencer_pkg::*;
#(
    parameter int unsigned RES  = 640,
    parameter int unsigned DIM  = 100,
    parameter int unsigned STEP = 2,
    parameter int unsigned P0   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] scale,
    output logic [9:0] pos
);

    dir_t        dir;
    logic [10:0] size;
    logic [11:0] reach;

    assign size  = 11'(scale) * 11'(DIM);
    // widened so pos+STEP+size cannot wrap before the edge compare
    assign reach = 12'(pos) + 12'(STEP) + 12'(size);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= 10'(P0);
            dir <= DIR_POS;
        end else if (tick) begin
            if (dir == DIR_POS) begin
                if (reach >= 12'(RES)) begin
                    pos <= 10'(11'(RES) - size);
                    dir <= DIR_NEG;
                end else begin
                    pos <= pos + 10'(STEP);
                end
            end else begin
                if (pos < 10'(STEP)) begin
                    pos <= '0;
                    dir <= DIR_POS;
                end else begin
                    pos <= pos - 10'(STEP);
                end
            end
        end
    end

endmodule

// File: rtl/heart_sequencer.sv
// Frame-synchronous lub-dub beat and bounce controller for the heart sprite renderer.
// Optional macro HEART_PULSE_SCALE_EN enlarges the sprite by one scale step during beats.
module heart_sequencer
    import heart_sequencer_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned WIDTH_ROM   = 100,
    parameter int unsigned HEIGHT_ROM  = 92,
    parameter int unsigned BASE_SCALE  = 2,
    parameter int unsigned ON_FRAMES   = 6,
    parameter int unsigned GAP_FRAMES  = 8,
    parameter int unsigned REST_FRAMES = 30,
    parameter int unsigned STEP        = 2,
    parameter int unsigned X0          = 64,
    parameter int unsigned Y0          = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       enable,
    output logic       show,
    output logic [9:0] x_scr,
    output logic [9:0] y_scr,
    output logic [3:0] wpixel,
    output logic [3:0] hpixel
);

    state_t     state, state_nx;
    logic [7:0] frame_cnt, cnt_nx;
    logic       last;
    logic       tick;
    logic       beat_nx;
    logic [3:0] scale_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = frame_cnt;
        tick     = 1'b0;
        last     = 1'b0;
        case (state)
            S_LUB, S_DUB: last = (frame_cnt == 8'(ON_FRAMES - 1));
            S_GAP:        last = (frame_cnt == 8'(GAP_FRAMES - 1));
            S_REST:       last = (frame_cnt == 8'(REST_FRAMES - 1));
            default:      last = 1'b0;
        endcase
        if (frame_start) begin
            if (!enable) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end else begin
                // every enabled frame moves the sprite, IDLE->LUB included
                tick   = 1'b1;
                cnt_nx = last ? '0 : frame_cnt + 8'd1;
                case (state)
                    S_IDLE: begin
                        state_nx = S_LUB;
                        cnt_nx   = '0;
                    end
                    S_LUB:   if (last) state_nx = S_GAP;
                    S_GAP:   if (last) state_nx = S_DUB;
                    S_DUB:   if (last) state_nx = S_REST;
                    S_REST:  if (last) state_nx = S_LUB;
                    default: begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end
                endcase
            end
        end
        beat_nx = is_beat(state_nx);
    end

`ifdef HEART_PULSE_SCALE_EN
    logic [3:0] scale_q;

    assign scale_nx = beat_nx ? 4'(BASE_SCALE + 1) : 4'(BASE_SCALE);
    assign wpixel   = scale_q;
    assign hpixel   = scale_q;

    always_ff @(posedge clk) begin
        if (rst) scale_q <= 4'(BASE_SCALE);
        else     scale_q <= scale_nx;
    end
`else
    assign scale_nx = 4'(BASE_SCALE);
    assign wpixel   = 4'(BASE_SCALE);
    assign hpixel   = 4'(BASE_SCALE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            frame_cnt <= '0;
            show      <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_cnt <= cnt_nx;
            show      <= beat_nx;
        end
    end

    // axes see the scale of the coming frame so a scale step also clamps position
    bounce_axis #(
        .RES (H_RES),
        .DIM (WIDTH_ROM),
        .STEP(STEP),
        .P0  (X0)
    ) u_axis_x (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .scale(scale_nx),
        .pos  (x_scr)
    );

    bounce_axis #(
        .RES (V_RES),
        .DIM (HEIGHT_ROM),
        .STEP(STEP),
        .P0  (Y0)
    ) u_axis_y (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .scale(scale_nx),
        .pos  (y_scr)
    );

endmodule

// File: tb/tb_heart_sequencer.sv
// Scoreboard bench for heart_sequencer: driver pushes expected outputs per frame, monitor compares.
module tb_heart_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       enable = 1'b0;
    logic       show;
    logic [9:0] x_scr, y_scr;
    logic [3:0] wpixel, hpixel;

    always #5 clk = ~clk;

    heart_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .enable     (enable),
        .show       (show),
        .x_scr      (x_scr),
        .y_scr      (y_scr),
        .wpixel     (wpixel),
        .hpixel     (hpixel)
    );

`ifdef HEART_PULSE_SCALE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    typedef struct packed {
        logic       show;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] w;
        logic [3:0] h;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // reference model state: 0 IDLE, 1 LUB, 2 GAP, 3 DUB, 4 REST
    int         m_state, m_cnt;
    logic [9:0] m_x, m_y;
    logic       m_dx, m_dy;
    logic [3:0] m_scale;

    function automatic logic [10:0] mv(input logic [9:0] p, input logic d,
                                       input int res, input int size);
        int   np;
        logic nd;
        np = int'(p);
        nd = d;
        if (!d) begin
            if (np + 2 + size >= res) begin np = res - size; nd = 1'b1; end
            else np = np + 2;
        end else begin
            if (np < 2) begin np = 0; nd = 1'b0; end
            else np = np - 2;
        end
        return {nd, 10'(np)};
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.show = (m_state == 1) || (m_state == 3);
        e.x = m_x;
        e.y = m_y;
        e.w = m_scale;
        e.h = m_scale;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0;
        m_x = 10'd64; m_y = 10'd48;
        m_dx = 1'b0; m_dy = 1'b0;
        m_scale = 4'd2;
    endtask

    task automatic model_frame(input logic en);
        int         dur;
        logic [10:0] r;
        if (!en) begin
            m_state = 0; m_cnt = 0; m_scale = 4'd2;
        end else begin
            dur = (m_state == 2) ? 8 : (m_state == 4) ? 30 : 6;
            if (m_state == 0) begin
                m_state = 1; m_cnt = 0;
            end else if (m_cnt == dur - 1) begin
                m_state = (m_state == 4) ? 1 : m_state + 1;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_scale = (PULSE && (m_state == 1 || m_state == 3)) ? 4'd3 : 4'd2;
            r = mv(m_x, m_dx, 640, int'(m_scale) * 100);
            {m_dx, m_x} = r;
            r = mv(m_y, m_dy, 480, int'(m_scale) * 92);
            {m_dy, m_y} = r;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; frame_start = 1'b1; enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            model_reset();
            q.push_back(model_out());
        end
        rst = 1'b0; frame_start = 1'b0;
    endtask

    // one frame: pulse frame_start, then wiggle enable mid-frame where it must be ignored
    task automatic frame(input logic en);
        @(negedge clk);
        enable = en; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        model_frame(en);
        q.push_back(model_out());
        repeat (3) @(negedge clk);
        enable = ~en;
        repeat (2) @(negedge clk);
        enable = en;
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp(input string name, input exp_t e);
        exp_t a;
        a = {show, x_scr, y_scr, wpixel, hpixel};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got show=%b x=%0d y=%0d w=%0d h=%0d want show=%b x=%0d y=%0d w=%0d h=%0d",
                     name, $time, a.show, a.x, a.y, a.w, a.h, e.show, e.x, e.y, e.w, e.h);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            have_cur = 1'b1;
            cmp("frame", cur);
        end else if (have_cur) begin
            cmp("hold", cur);
        end
    end

    initial begin
        int guard;
        do_reset(2);
        repeat (4) frame(1'b1);
        // reset lands mid-LUB with frame_start held high
        do_reset(3);
        repeat (470) frame(1'b1);
        guard = 0;
        while (m_state != 3 && guard < 60) begin
            frame(1'b1);
            guard++;
        end
        checks++;
        if (m_state != 3) begin
            errors++;
            $display("FAIL reach_dub got state=%0d want state=3", m_state);
        end
        repeat (3) frame(1'b0);
        repeat (60) frame(1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
